// File: rtl/prince_cms_pkg.sv
// Shared types for the masked PRINCE S-box layer sequencer.
// Share s of a state occupies bits [s*4*NNIB +: 4*NNIB].
package prince_cms_pkg;

    localparam int NSHARES = 3;
    localparam int NNIB    = 16;

    typedef logic [3:0] nib_t;
    typedef nib_t [NSHARES-1:0] shnib_t;
    typedef logic [NSHARES-1:0][4*NNIB-1:0] shstate_t;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } seq_st_e;

endpackage

// File: rtl/sbox_token_tracker.sv
// Follows issued nibbles through the S-box core latency and
// produces the in-place write-back strobe and target index.
module sbox_token_tracker #(
    parameter int NNIB     = 16,
    parameter int PIPE_LAT = 2,
    parameter int CW       = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_adv,
    input  logic          i_tok,
    output logic          o_wb_en,
    output logic [CW-1:0] o_wb_idx,
    output logic          o_wb_last
);

    logic [PIPE_LAT-1:0] r_pipe;
    logic [CW-1:0]       r_wb_idx;
    logic                w_tok_out;
    logic                w_idx_last;

    assign w_tok_out  = r_pipe[PIPE_LAT-1];
    assign w_idx_last = (r_wb_idx == CW'(NNIB - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe   <= '0;
            r_wb_idx <= '0;
        end else if (i_clr) begin
            r_pipe   <= '0;
            r_wb_idx <= '0;
        end else if (i_adv) begin
            r_pipe[0] <= i_tok;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            if (w_tok_out) begin
                r_wb_idx <= w_idx_last ? '0 : r_wb_idx + CW'(1);
            end
        end
    end

    assign o_wb_en   = i_adv & w_tok_out;
    assign o_wb_idx  = r_wb_idx;
    assign o_wb_last = o_wb_en & w_idx_last;

endmodule

// File: rtl/prince_sbox_layer_seq.sv
// Serialises a shared 64-bit state through an external shared PRINCE
// S-box core one nibble per advance, writing results back in place.
module prince_sbox_layer_seq #(
    parameter int NSHARES  = 3,
    parameter int NNIB     = 16,
    parameter int PIPE_LAT = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [NSHARES*4*NNIB-1:0] i_state,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [NSHARES*4*NNIB-1:0] o_state,
    output logic [NSHARES*4-1:0]      o_sb_in,
    output logic                      o_sb_en,
    input  logic [NSHARES*4-1:0]      i_sb_out,
    input  logic                      i_rnd_valid,
    output logic                      o_rnd_ready
);
    import prince_cms_pkg::*;

    localparam int SW = 4 * NNIB;
    localparam int CW = (NNIB > 1) ? $clog2(NNIB) : 1;

    seq_st_e                    r_st;
    logic [NSHARES-1:0][SW-1:0] r_state;
    logic [CW-1:0]              r_issue;
    logic                       r_busy;
    logic                       r_done;

    logic                       w_feed;
    logic                       w_adv;
    logic                       w_load;
    logic                       w_issue_last;
    logic                       w_wb_en;
    logic                       w_wb_last;
    logic [CW-1:0]              w_wb_idx;
    nib_t [NSHARES-1:0]         w_sb_in;
    nib_t [NSHARES-1:0]         w_sb_out;

    assign w_feed       = (r_st == FEED);
    assign w_adv        = (w_feed || r_st == DRAIN) && i_rnd_valid;
    assign w_load       = (r_st == IDLE) && i_start;
    assign w_issue_last = (r_issue == CW'(NNIB - 1));
    assign w_sb_out     = i_sb_out;

    sbox_token_tracker #(
        .NNIB     (NNIB),
        .PIPE_LAT (PIPE_LAT),
        .CW       (CW)
    ) u_trk (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_load),
        .i_adv     (w_adv),
        .i_tok     (w_feed),
        .o_wb_en   (w_wb_en),
        .o_wb_idx  (w_wb_idx),
        .o_wb_last (w_wb_last)
    );

    // Outside FEED the core sees zero so no two shares ever meet.
    always_comb begin
        w_sb_in = '0;
        if (w_feed) begin
            for (int s = 0; s < NSHARES; s++) begin
                w_sb_in[s] = r_state[s][{r_issue, 2'b00} +: 4];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st    <= IDLE;
            r_state <= '0;
            r_issue <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_st)
                IDLE: begin
                    if (i_start) begin
                        r_st    <= FEED;
                        r_busy  <= 1'b1;
                        r_issue <= '0;
                    end
                end
                FEED: begin
                    if (w_adv) begin
                        r_issue <= w_issue_last ? '0 : r_issue + CW'(1);
                        if (w_issue_last) begin
                            r_st <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_wb_last) begin
                        r_st   <= DONE;
                        r_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_st   <= IDLE;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_st <= IDLE;
                end
            endcase
            if (w_load) begin
                r_state <= i_state;
            end else if (w_wb_en) begin
                for (int s = 0; s < NSHARES; s++) begin
                    r_state[s][{w_wb_idx, 2'b00} +: 4] <= w_sb_out[s];
                end
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_state     = r_state;
    assign o_sb_in     = w_sb_in;
    assign o_sb_en     = w_adv;
    assign o_rnd_ready = w_adv;

endmodule

// File: tb/tb_prince_sbox_layer_seq.sv
// Bench for prince_sbox_layer_seq with a masked S-box core stub.
// Expected outputs come from an advance-count model of the sequencer.
module tb_prince_sbox_layer_seq;

    localparam int NSH  = 3;
    localparam int NNIB = 16;
    localparam int PL   = 2;
    localparam int W    = NSH * 4 * NNIB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rnd_valid = 1'b0;
    logic [W-1:0]  st_in = '0;
    logic          o_busy, o_done, sb_en, rnd_ready;
    logic [W-1:0]  o_state;
    logic [11:0]   sb_in, sb_out;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    prince_sbox_layer_seq #(
        .NSHARES  (NSH),
        .NNIB     (NNIB),
        .PIPE_LAT (PL)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_state     (st_in),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_state     (o_state),
        .o_sb_in     (sb_in),
        .o_sb_en     (sb_en),
        .i_sb_out    (sb_out),
        .i_rnd_valid (rnd_valid),
        .o_rnd_ready (rnd_ready)
    );

    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h4D5E087619CA23FB;
        return t[4*x +: 4];
    endfunction

    function automatic logic [63:0] sbox64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < NNIB; i++) r[4*i +: 4] = sb(x[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] xr(input logic [W-1:0] s);
        return s[63:0] ^ s[127:64] ^ s[191:128];
    endfunction

    function automatic logic [11:0] nib3(input logic [W-1:0] s, input int i);
        return {s[128+4*i +: 4], s[64+4*i +: 4], s[4*i +: 4]};
    endfunction

    // Masked core stub: two enabled stages, output shares XOR to S(x).
    logic [11:0] c1, c2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1 <= '0;
            c2 <= '0;
        end else if (sb_en) begin
            c1 <= sb_in;
            c2 <= c1;
        end
    end
    always_comb begin
        sb_out[11:8] = c2[11:8];
        sb_out[7:4]  = c2[7:4];
        sb_out[3:0]  = sb(c2[3:0] ^ c2[7:4] ^ c2[11:8]) ^ c2[7:4] ^ c2[11:8];
    end

    task automatic chk(input string nm, input logic [W-1:0] a,
                       input logic [W-1:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    // Model: phase 0 idle, 1 running, 2 done; k counts advances.
    int           phase;
    int           k;
    logic [W-1:0] ld;
    logic [63:0]  res;
    logic         res_v;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 0;
            k     <= 0;
            ld    <= '0;
            res   <= '0;
            res_v <= 1'b0;
        end else begin
            case (phase)
                0: if (start) begin
                    phase <= 1;
                    k     <= 0;
                    ld    <= st_in;
                end
                1: if (rnd_valid) begin
                    k <= k + 1;
                    if (k + 1 == NNIB + PL) begin
                        phase <= 2;
                        res   <= sbox64(xr(ld));
                        res_v <= 1'b1;
                    end
                end
                default: phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [11:0] e_in;
        e_in = (phase == 1 && k < NNIB) ? nib3(ld, k) : 12'h000;
        chk("busy", W'(o_busy), W'(phase != 0));
        chk("done", W'(o_done), W'(phase == 2));
        chk("sb_en", W'(sb_en), W'(phase == 1 && rnd_valid));
        chk("rnd_ready", W'(rnd_ready), W'(phase == 1 && rnd_valid));
        chk("sb_in", W'(sb_in), W'(e_in));
        if (phase == 2 || (phase == 0 && res_v))
            chk("state_xor", W'(xr(o_state)), W'(res));
        else if (phase == 0)
            chk("state_zero", o_state, '0);
        if (o_done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input logic [W-1:0] st, input logic [63:0] stall,
                       input logic [63:0] spulse, input logic [W-1:0] alt,
                       output int lat, output int enmax,
                       output logic [63:0] ox);
        int rl;
        lat = 0;
        enmax = 0;
        rl = 0;
        st_in = st;
        start = 1'b1;
        rnd_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 60; c++) begin
            rnd_valid = !stall[c];
            start = spulse[c];
            if (spulse[c]) st_in = alt;
            @(negedge clk);
            if (sb_en) begin
                rl++;
                if (rl > enmax) enmax = rl;
            end else begin
                rl = 0;
            end
            if (o_done) begin
                lat = c;
                break;
            end
            tick();
        end
        tick();
        start = 1'b0;
        rnd_valid = 1'b1;
        ox = xr(o_state);
    endtask

    localparam logic [63:0] P2 = 64'h0123456789ABCDEF;
    localparam logic [63:0] P3 = 64'hFEDCBA9876543210;
    localparam logic [63:0] M1 = 64'h5A3C96F01E2D4B87;
    localparam logic [63:0] M2 = 64'hC3A50F69B1D2E478;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] v2, v3, va;
        logic [63:0]  ox;
        int           lat, enmax, d0;
        v2 = {M2, M1, P2 ^ M1 ^ M2};
        v3 = {M1, M2, P3 ^ M1 ^ M2};
        va = {M1, M2, 64'hDEADBEEFCAFEF00D};

        #2;
        chk("rst_busy", W'(o_busy), '0);
        chk("rst_done", W'(o_done), '0);
        chk("rst_sb_en", W'(sb_en), '0);
        chk("rst_state", o_state, '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: all-zero shares
        run('0, 64'd0, 64'd0, '0, lat, enmax, ox);
        chk("t1_lat", W'(lat), W'(19));
        chk("t1_enrun", W'(enmax), W'(18));
        chk("t1_xor", W'(ox), W'(64'hBBBBBBBBBBBBBBBB));

        // 2 + 6: started the cycle after the previous done
        run(v2, 64'd0, 64'd0, '0, lat, enmax, ox);
        chk("t2_lat", W'(lat), W'(19));
        chk("t2_xor", W'(ox), W'(64'hBF32AC916780E5D4));

        // 3: randomness stalls
        run(v2, (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 10), 64'd0, '0,
            lat, enmax, ox);
        chk("t3_lat", W'(lat), W'(22));
        chk("t3_xor", W'(ox), W'(64'hBF32AC916780E5D4));

        // 4: start pulses in FEED and DONE are ignored
        d0 = n_done;
        run(v2, 64'd0, (64'd1 << 5) | (64'd1 << 19), va, lat, enmax, ox);
        repeat (4) tick();
        chk("t4_lat", W'(lat), W'(19));
        chk("t4_xor", W'(ox), W'(64'hBF32AC916780E5D4));
        chk("t4_ndone", W'(n_done - d0), W'(1));
        chk("t4_busy", W'(o_busy), '0);

        // 5: asynchronous abort while nibble 7 is issuing
        st_in = v2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("t5_sb_in7", W'(sb_in), W'(nib3(v2, 7)));
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", W'(o_busy), '0);
        chk("t5_done", W'(o_done), '0);
        chk("t5_sb_en", W'(sb_en), '0);
        chk("t5_state", o_state, '0);
        tick();
        rst_n = 1'b1;
        tick();
        run(v3, 64'd0, 64'd0, '0, lat, enmax, ox);
        chk("t5_lat", W'(lat), W'(19));
        chk("t5_xor", W'(ox), W'(64'h4D5E087619CA23FB));

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
